// File: rtl/mux_n_to_1_reg.sv
// rtl/mux_n_to_1_reg.sv - N:1 channel selector with a registered valid/ready output stage
// Optional transfer counter (xfer_cnt, cnt_clr) is enabled by defining MUX_XFER_CNT_EN.
module mux_n_to_1_reg #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
`ifdef MUX_XFER_CNT_EN
  input  logic                      cnt_clr,
  output logic [15:0]               xfer_cnt,
`endif
  input  logic                      out_ready
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_valid;
  logic [WIDTH-1:0] grant_data;
  logic [SEL_W-1:0] next_ptr;
  logic             can_load;
  logic             xfer;

  assign can_load = !out_valid || out_ready;

  // Round-robin scan starts at rr_ptr and wraps; rr_ptr is always < CHANNELS.
  always_comb begin : grant_sel
    int j;
    j           = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (!mode) begin
      if (int'(sel) < CHANNELS) begin
        grant_valid = 1'b1;
        grant_idx   = sel;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        j = int'(rr_ptr) + i;
        if (j >= CHANNELS) j = j - CHANNELS;
        if (!grant_valid && in_valid[j]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(j);
        end
      end
    end
  end

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant_idx == SEL_W'(k)) begin
        grant_data  = in_data[k*WIDTH +: WIDTH];
        in_ready[k] = grant_valid && can_load && !rst;
      end
    end
  end

  assign xfer     = |(in_valid & in_ready);
  assign next_ptr = (int'(grant_idx) + 1 == CHANNELS) ? '0 : grant_idx + SEL_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      out_data  <= grant_data;
      out_chan  <= grant_idx;
      out_valid <= 1'b1;
      if (mode) rr_ptr <= next_ptr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_XFER_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (cnt_clr) begin
      xfer_cnt <= '0;
    end else if (xfer && xfer_cnt != 16'hFFFF) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_n_to_1_reg.sv
// tb/tb_mux_n_to_1_reg.sv - directed bench for mux_n_to_1_reg (4-channel and 3-channel instances)
module tb_mux_n_to_1_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ch [4];
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  logic [15:0] ch3 [3];
  logic [47:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [1:0]  sel3;
  logic [15:0] out_data3;
  logic [1:0]  out_chan3;
  logic        out_valid3;
  logic        out_ready3;

`ifdef MUX_XFER_CNT_EN
  logic        cnt_clr;
  logic [15:0] xfer_cnt;
  logic [15:0] xfer_cnt3;
`endif

  int n_vec = 0;
  int n_miscompare = 0;

  assign in_data  = {ch[3], ch[2], ch[1], ch[0]};
  assign in_data3 = {ch3[2], ch3[1], ch3[0]};

  always #5 clk = ~clk;

  mux_n_to_1_reg #(.WIDTH(16), .CHANNELS(4), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
`ifdef MUX_XFER_CNT_EN
    .cnt_clr(cnt_clr), .xfer_cnt(xfer_cnt),
`endif
    .out_ready(out_ready)
  );

  mux_n_to_1_reg #(.WIDTH(16), .CHANNELS(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(1'b0), .sel(sel3), .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
`ifdef MUX_XFER_CNT_EN
    .cnt_clr(1'b0), .xfer_cnt(xfer_cnt3),
`endif
    .out_ready(out_ready3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] rr_exp [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [1:0] rr2_exp [4] = '{2'd1, 2'd3, 2'd1, 2'd3};

  initial begin
    rst = 1'b1; mode = 1'b0; sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) ch[k] = 16'h1100 * 16'(k + 1);
    in_valid3 = 3'b000; sel3 = 2'd0; out_ready3 = 1'b1;
    for (int k = 0; k < 3; k++) ch3[k] = 16'h3000 + 16'(k);
`ifdef MUX_XFER_CNT_EN
    cnt_clr = 1'b0;
`endif
    // reset state
    repeat (2) tick();
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_chan", 32'(out_chan), 32'h0);
    @(negedge clk); rst = 1'b0; #1;
    check("post_rst_in_ready", 32'(in_ready), 32'h4);
    tick();
    check("first_valid", 32'(out_valid), 32'h1);
    check("first_data", 32'(out_data), 32'h3300);
    check("first_chan", 32'(out_chan), 32'h2);

    // fixed-mode back-to-back
    sel = 2'd1; ch[1] = 16'h1234;
    tick();
    check("b2b_data0", 32'(out_data), 32'h1234);
    check("b2b_chan0", 32'(out_chan), 32'h1);
    ch[1] = 16'hABCD;
    tick();
    check("b2b_data1", 32'(out_data), 32'hABCD);
    check("b2b_valid1", 32'(out_valid), 32'h1);

    // stall
    ch[1] = 16'h00FF;
    tick();
    check("stall_load", 32'(out_data), 32'h00FF);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sel = 2'(c); ch[c] = 16'hDEAD + 16'(c); #1;
      check("stall_in_ready", 32'(in_ready), 32'h0);
      tick();
      check("stall_data", 32'(out_data), 32'h00FF);
      check("stall_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1; sel = 2'd0; ch[0] = 16'h5A5A;
    tick();
    check("unstall_data", 32'(out_data), 32'h5A5A);
    check("unstall_chan", 32'(out_chan), 32'h0);

    // drain with nothing valid
    in_valid = 4'h0;
    tick();
    check("drain_valid", 32'(out_valid), 32'h0);
    check("drain_data_kept", 32'(out_data), 32'h5A5A);

    // round-robin, all valid
    mode = 1'b1; in_valid = 4'hF;
    for (int k = 0; k < 4; k++) ch[k] = 16'hC000 + 16'(k);
    #1;
    check("rr_in_ready0", 32'(in_ready), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr_all_chan", 32'(out_chan), 32'(rr_exp[i]));
      check("rr_all_data", 32'(out_data), 32'h0000C000 + 32'(rr_exp[i]));
    end
    // only ch1 and ch3 valid, pointer now at 1
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_sparse_chan", 32'(out_chan), 32'(rr2_exp[i]));
    end

    // async reset mid-transfer discards the held word
    out_ready = 1'b0;
    #2 rst = 1'b1; #1;
    check("async_rst_valid", 32'(out_valid), 32'h0);
    check("async_rst_in_ready", 32'(in_ready), 32'h0);
    @(negedge clk); rst = 1'b0;
    in_valid = 4'h0; mode = 1'b0; out_ready = 1'b1;

    // invalid select on 3-channel instance
    in_valid3 = 3'b111; sel3 = 2'd1;
    tick();
    check("c3_load_valid", 32'(out_valid3), 32'h1);
    check("c3_load_data", 32'(out_data3), 32'h3001);
    sel3 = 2'd3; out_ready3 = 1'b0; #1;
    check("c3_badsel_in_ready", 32'(in_ready3), 32'h0);
    tick();
    check("c3_hold_valid", 32'(out_valid3), 32'h1);
    out_ready3 = 1'b1;
    tick();
    check("c3_drop_valid", 32'(out_valid3), 32'h0);
    check("c3_in_ready_still0", 32'(in_ready3), 32'h0);

`ifdef MUX_XFER_CNT_EN
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    check("cnt_rst", 32'(xfer_cnt), 32'h0);
    sel = 2'd0; in_valid = 4'h1; out_ready = 1'b1;
    repeat (5) tick();
    check("cnt_five", 32'(xfer_cnt), 32'h5);
    cnt_clr = 1'b1;
    tick();
    check("cnt_clr_prio", 32'(xfer_cnt), 32'h0);
    cnt_clr = 1'b0;
    repeat (65535) tick();
    check("cnt_reach_max", 32'(xfer_cnt), 32'hFFFF);
    repeat (2) tick();
    check("cnt_saturate", 32'(xfer_cnt), 32'hFFFF);
    in_valid = 4'h0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule

// File: doc/mux_n_to_1_reg.md
Name: mux_n_to_1_reg

Overview:
- Parametrised successor to the fixed 16-bit 2:1 selector: N input channels, W bits each, one registered output with valid/ready handshake on every channel.
- Two modes: fixed select (software/decoder picks the channel) or round-robin arbitration among valid channels.
- Sits between multiple producers (e.g. ALU result, memory read data, immediate path, PC+1) and a single consumer stage.

Parameters:
- WIDTH, 16, data bits per channel
- CHANNELS, 4, number of input channels (2..16)
- SEL_W, 2, select/index width; must satisfy 2**SEL_W >= CHANNELS

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active high
- in_data  input  CHANNELS*WIDTH  packed channel data; channel k = in_data[k*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready; combinational
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SEL_W  channel index used when mode=0
- out_data  output  WIDTH  registered selected data
- out_chan  output  SEL_W  registered index of the channel that supplied out_data
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts the word

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_chan=0, rr_ptr=0, optional counter=0. Asserting rst mid-transfer discards the held word. in_ready is all zero while rst=1.
- can_load = !out_valid | out_ready. The output register is a single-entry pipeline stage: throughput is 1 word/cycle and latency is 1 cycle from input handshake to out_valid.
- Grant, fixed mode (mode=0):
  - g = sel, provided sel < CHANNELS.
  - in_ready[g] = can_load. All other in_ready bits are 0.
  - If sel >= CHANNELS, no grant is made and in_ready = 0.
- Grant, round-robin mode (mode=1):
  - g = first k with in_valid[k]=1, scanning rr_ptr, rr_ptr+1, … modulo CHANNELS.
  - in_ready[g] = can_load. All other in_ready bits are 0.
  - If no channel is valid, in_ready = 0.
- Transfer on channel g occurs when in_valid[g] & in_ready[g]. At the clock edge:
  - out_data <= channel g data
  - out_chan <= g
  - out_valid <= 1
  - In mode=1 only: rr_ptr <= (g+1 == CHANNELS) ? 0 : g+1
- No transfer and out_ready=1 at the edge: out_valid <= 0. out_data and out_chan keep their last values.
- Stall (out_valid=1, out_ready=0): out_data, out_chan and out_valid hold stable. Changes to mode, sel or inputs during a stall do not affect the registered output.
- Simultaneous out_ready=1 and a new transfer: the old word is consumed and the new word is loaded in the same edge, with no bubble.
- rr_ptr is unchanged in mode=0. Switching mode takes effect on the next grant evaluation.

Optional Feature:
- Macro: MUX_XFER_CNT_EN.
- Defined:
  - Adds output port xfer_cnt [15:0], reset to 0.
  - Increments by 1 on each input transfer and saturates at 16'hFFFF.
  - Also adds input cnt_clr [1]: synchronous clear to 0, which takes priority over increment.
- Not defined: neither port exists and there is no counter logic.

Test Plan:
- Reset: rst=1 with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0; after release, mode=0 and sel=2 -> first edge loads ch2 data, out_chan=2.
- Fixed mode back-to-back: sel=1, ch1 data 16'h1234 then 16'hABCD, out_ready=1 -> out_data 16'h1234 then 16'hABCD on consecutive cycles, out_valid held at 1.
- Stall: out_valid=1 holding 16'h00FF, out_ready=0 for 3 cycles while ch data and sel change -> out_data stays 16'h00FF and in_ready=0; out_ready=1 -> new word loads on that edge.
- Round-robin: mode=1, all 4 channels valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0; with only ch1 and ch3 valid -> 1,3,1,3.
- Invalid select: CHANNELS=3, SEL_W=2, sel=3 -> in_ready=0 and out_valid drops to 0 after the current word is consumed.
- With MUX_XFER_CNT_EN: 5 transfers -> xfer_cnt=5; cnt_clr=1 together with a transfer -> xfer_cnt=0; preload near 16'hFFFF by running transfers -> count stays at 16'hFFFF.
